// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode/exec plus iterative MUL, handshaked memory access and flag branches.
// Moore outputs decoded from the registered state, qualified by opcode and flags; MEM waits on MEM_READY.
module multicycle_ctrl #(
  parameter int IW        = 16,
  parameter int MUL_STEPS = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [IW-1:0] INSTR,
  input  logic          Z_FLAG,
  input  logic          N_FLAG,
  input  logic          MEM_READY,
  output logic          INST_REG_EN,
  output logic          PC_EN,
  output logic [1:0]    PC_MUX_SEL,
  output logic [1:0]    A_SEL,
  output logic [1:0]    B_SEL,
  output logic [1:0]    D_SEL,
  output logic [2:0]    OAP,
  output logic          LDA,
  output logic          LDQ,
  output logic          SR,
  output logic          MULT_EN,
  output logic          RF_EN,
  output logic          WR_EN,
  output logic          WB_SEL,
  output logic          ILLEGAL,
  output logic [3:0]    STATE
);

  localparam int CW = $clog2(MUL_STEPS + 1);

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ANDI = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_BLT  = 4'b0111;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC     = 4'd3,
    S_MUL_LOAD = 4'd4,
    S_MUL_STEP = 4'd5,
    S_MEM      = 4'd6,
    S_WB       = 4'd7,
    S_BRANCH   = 4'd8,
    S_HALT     = 4'd9
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    opc;
  logic          is_alu;
  logic          is_mem;
  logic          is_br;
  logic          taken;
  logic          unused_bits;

  assign opc         = INSTR[IW-1:IW-4];
  assign is_alu      = (opc == OP_R) || (opc == OP_ADDI) || (opc == OP_ANDI);
  assign is_mem      = (opc == OP_LW) || (opc == OP_SW);
  assign is_br       = (opc == OP_BEQ) || (opc == OP_BLT);
  assign taken       = ((opc == OP_BEQ) && Z_FLAG) || ((opc == OP_BLT) && N_FLAG);
  assign unused_bits = ^INSTR[IW-5:3];
  assign STATE       = state;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Step counter: loaded in MUL_LOAD, counts down through MUL_STEP, exit on zero.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (state == S_MUL_LOAD) begin
      cnt <= CW'(MUL_STEPS - 1);
    end else if ((state == S_MUL_STEP) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:     nxt = S_FETCH;
      S_FETCH:    nxt = S_DECODE;
      S_DECODE: begin
        if (is_alu || is_mem || is_br) nxt = S_EXEC;
        else if (opc == OP_MUL)        nxt = S_MUL_LOAD;
        else if (opc == OP_HALT)       nxt = S_HALT;
        else                           nxt = S_FETCH;
      end
      S_EXEC: begin
        if (is_mem)     nxt = S_MEM;
        else if (is_br) nxt = S_BRANCH;
        else            nxt = S_WB;
      end
      S_MUL_LOAD: nxt = S_MUL_STEP;
      S_MUL_STEP: if (cnt == '0) nxt = S_WB;
      S_MEM:      if (MEM_READY) nxt = (opc == OP_SW) ? S_FETCH : S_WB;
      S_WB:       nxt = S_FETCH;
      S_BRANCH:   nxt = S_FETCH;
      S_HALT:     nxt = S_HALT;
      default:    nxt = S_IDLE;
    endcase
  end

  always_comb begin
    INST_REG_EN = 1'b0;
    PC_EN       = 1'b0;
    PC_MUX_SEL  = 2'b00;
    A_SEL       = 2'b00;
    B_SEL       = 2'b00;
    D_SEL       = 2'b00;
    OAP         = 3'b000;
    LDA         = 1'b0;
    LDQ         = 1'b0;
    SR          = 1'b0;
    MULT_EN     = 1'b0;
    RF_EN       = 1'b0;
    WR_EN       = 1'b0;
    WB_SEL      = 1'b0;
    ILLEGAL     = 1'b0;
    case (state)
      S_FETCH: begin
        INST_REG_EN = 1'b1;
        PC_EN       = 1'b1;
      end
      S_DECODE: ILLEGAL = !(is_alu || is_mem || is_br || (opc == OP_MUL) || (opc == OP_HALT));
      S_EXEC: begin
        LDA   = 1'b1;
        A_SEL = 2'b10;
        B_SEL = ((opc == OP_R) || is_br) ? 2'b10 : 2'b11;
        if (opc == OP_R)         OAP = INSTR[2:0];
        else if (opc == OP_ANDI) OAP = 3'b100;
        else if (is_br)          OAP = 3'b001;
        else                     OAP = 3'b000;
      end
      S_MUL_LOAD: begin
        LDQ     = 1'b1;
        MULT_EN = 1'b1;
      end
      S_MUL_STEP: begin
        MULT_EN = 1'b1;
        SR      = 1'b1;
        LDA     = 1'b1;
      end
      S_MEM: WR_EN = (opc == OP_SW);
      S_WB: begin
        RF_EN  = 1'b1;
        D_SEL  = 2'b01;
        WB_SEL = (opc == OP_LW);
      end
      S_BRANCH: begin
        PC_EN      = taken;
        PC_MUX_SEL = taken ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
  end

endmodule
